// File: rtl/bsg_manycore_npa_req_issue.sv
// Remote-request issue stage: drops invalid translations, queues valid requests and issues them under a credit limit.
// The optional stall-cycle counter is enabled with `define BSG_MANYCORE_NPA_REQ_STALL_CTR_EN.
module bsg_manycore_npa_req_issue #(
  parameter int data_width_p      = 32,
  parameter int addr_width_p      = 28,
  parameter int x_cord_width_p    = 7,
  parameter int y_cord_width_p    = 7,
  parameter int fifo_els_p        = 2,
  parameter int max_out_credits_p = 32,
  localparam int mask_width_lp    = data_width_p/8,
  localparam int credit_width_lp  = $clog2(max_out_credits_p+1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,

  input  logic                       req_v_i,
  output logic                       req_ready_o,
  input  logic [x_cord_width_p-1:0]  req_x_cord_i,
  input  logic [y_cord_width_p-1:0]  req_y_cord_i,
  input  logic [addr_width_p-1:0]    req_epa_i,
  input  logic [data_width_p-1:0]    req_data_i,
  input  logic [mask_width_lp-1:0]   req_mask_i,
  input  logic                       req_is_store_i,
  input  logic                       req_invalid_i,

  output logic                       pkt_v_o,
  input  logic                       pkt_ready_i,
  output logic [x_cord_width_p-1:0]  pkt_x_cord_o,
  output logic [y_cord_width_p-1:0]  pkt_y_cord_o,
  output logic [addr_width_p-1:0]    pkt_epa_o,
  output logic [data_width_p-1:0]    pkt_data_o,
  output logic [mask_width_lp-1:0]   pkt_mask_o,
  output logic                       pkt_is_store_o,

  input  logic                       credit_return_i,
  output logic [credit_width_lp-1:0] out_credits_o,

  input  logic                       fence_v_i,
  output logic                       fence_ready_o,
  output logic                       fence_done_o,

  output logic                       err_o,
  input  logic                       err_clear_i
`ifdef BSG_MANYCORE_NPA_REQ_STALL_CTR_EN
  ,
  output logic [31:0]                stall_cycles_o
`endif
);

  localparam int ptr_width_lp   = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_width_lp   = $clog2(fifo_els_p+1);
  localparam int entry_width_lp = x_cord_width_p + y_cord_width_p + addr_width_p
                                  + data_width_p + mask_width_lp + 1;
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);
  localparam logic [cnt_width_lp-1:0]    fifo_full_lp   = cnt_width_lp'(fifo_els_p);
  localparam logic [ptr_width_lp-1:0]    last_ptr_lp    = ptr_width_lp'(fifo_els_p-1);

  typedef enum logic [0:0] {e_run, e_fence_wait} state_e;

  function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] ptr);
    return (ptr == last_ptr_lp) ? '0 : ptr + ptr_width_lp'(1);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_e                     state_r;
  logic [entry_width_lp-1:0]  fifo_mem [fifo_els_p];
  logic [ptr_width_lp-1:0]    wr_ptr_r, rd_ptr_r;
  logic [cnt_width_lp-1:0]    count_r;
  logic [credit_width_lp-1:0] credits_r;
  logic                       fence_done_r, err_r;

  logic fifo_empty, fifo_full, credits_full;
  logic req_accept, enq, drop, issue, fence_accept;

  assign fifo_empty   = (count_r == '0);
  assign fifo_full    = (count_r == fifo_full_lp);
  assign credits_full = (credits_r == max_credits_lp);

  // A full FIFO stays unready even when it dequeues this cycle; no bypass path.
  assign req_ready_o   = (state_r == e_run) & ~fifo_full;
  assign fence_ready_o = (state_r == e_run);
  assign req_accept    = req_v_i & req_ready_o;
  assign enq           = req_accept & ~req_invalid_i;
  assign drop          = req_accept &  req_invalid_i;
  assign fence_accept  = fence_v_i & fence_ready_o;

  assign pkt_v_o = ~fifo_empty & (credits_r != '0);
  assign issue   = pkt_v_o & pkt_ready_i;

  assign {pkt_x_cord_o, pkt_y_cord_o, pkt_epa_o, pkt_data_o, pkt_mask_o, pkt_is_store_o}
    = fifo_mem[rd_ptr_r];

  assign out_credits_o = credits_r;
  assign fence_done_o  = fence_done_r;
  assign err_o         = err_r;

  // ---- enqueue stage: payload storage, not reset
  always_ff @(posedge clk_i) begin
    if (enq)
      fifo_mem[wr_ptr_r] <= {req_x_cord_i, req_y_cord_i, req_epa_i,
                             req_data_i, req_mask_i, req_is_store_i};
  end

  // ---- issue stage: pointers, occupancy, credits, error flag and fence FSM
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      credits_r    <= max_credits_lp;
      state_r      <= e_run;
      fence_done_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      if (enq)   wr_ptr_r <= next_ptr(wr_ptr_r);
      if (issue) rd_ptr_r <= next_ptr(rd_ptr_r);

      case ({enq, issue})
        2'b10:   count_r <= count_r + cnt_width_lp'(1);
        2'b01:   count_r <= count_r - cnt_width_lp'(1);
        default: count_r <= count_r;
      endcase

      // A return with nothing outstanding holds at max rather than wrapping.
      case ({issue, credit_return_i})
        2'b10:   credits_r <= credits_r - credit_width_lp'(1);
        2'b01:   credits_r <= credits_full ? credits_r : credits_r + credit_width_lp'(1);
        default: credits_r <= credits_r;
      endcase

      if (drop)             err_r <= 1'b1;
      else if (err_clear_i) err_r <= 1'b0;

      fence_done_r <= 1'b0;
      case (state_r)
        e_run: begin
          if (fence_accept) begin
            if (fifo_empty & credits_full & ~req_accept) fence_done_r <= 1'b1;
            else                                         state_r      <= e_fence_wait;
          end
        end
        e_fence_wait: begin
          if (fifo_empty & credits_full) begin
            fence_done_r <= 1'b1;
            state_r      <= e_run;
          end
        end
        default: state_r <= e_run;
      endcase
    end
  end

`ifdef BSG_MANYCORE_NPA_REQ_STALL_CTR_EN
  logic [31:0] stall_cycles_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                  stall_cycles_r <= '0;
    else if (~fifo_empty & ~issue) stall_cycles_r <= sat_inc32(stall_cycles_r);
  end

  assign stall_cycles_o = stall_cycles_r;
`else
  logic [31:0] stall_unused;
  assign stall_unused = sat_inc32(32'd0);
`endif

  credit_overflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !(credit_return_i && !issue && credits_full));

endmodule

// File: tb/tb_bsg_manycore_npa_req_issue.sv
// Directed bench for bsg_manycore_npa_req_issue: issue, credit limit, invalid drop, fences, stall and async reset.
module tb_bsg_manycore_npa_req_issue;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_v_i, req_ready_o;
  logic [6:0]  req_x_cord_i, req_y_cord_i;
  logic [27:0] req_epa_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_mask_i;
  logic        req_is_store_i, req_invalid_i;
  logic        pkt_v_o, pkt_ready_i;
  logic [6:0]  pkt_x_cord_o, pkt_y_cord_o;
  logic [27:0] pkt_epa_o;
  logic [31:0] pkt_data_o;
  logic [3:0]  pkt_mask_o;
  logic        pkt_is_store_o;
  logic        credit_return_i;
  logic [5:0]  out_credits_o;
  logic        fence_v_i, fence_ready_o, fence_done_o;
  logic        err_o, err_clear_i;
`ifdef BSG_MANYCORE_NPA_REQ_STALL_CTR_EN
  logic [31:0] stall_cycles_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  bsg_manycore_npa_req_issue dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_ready_o(req_ready_o),
    .req_x_cord_i(req_x_cord_i), .req_y_cord_i(req_y_cord_i), .req_epa_i(req_epa_i),
    .req_data_i(req_data_i), .req_mask_i(req_mask_i),
    .req_is_store_i(req_is_store_i), .req_invalid_i(req_invalid_i),
    .pkt_v_o(pkt_v_o), .pkt_ready_i(pkt_ready_i),
    .pkt_x_cord_o(pkt_x_cord_o), .pkt_y_cord_o(pkt_y_cord_o), .pkt_epa_o(pkt_epa_o),
    .pkt_data_o(pkt_data_o), .pkt_mask_o(pkt_mask_o), .pkt_is_store_o(pkt_is_store_o),
    .credit_return_i(credit_return_i), .out_credits_o(out_credits_o),
    .fence_v_i(fence_v_i), .fence_ready_o(fence_ready_o), .fence_done_o(fence_done_o),
    .err_o(err_o), .err_clear_i(err_clear_i)
`ifdef BSG_MANYCORE_NPA_REQ_STALL_CTR_EN
    , .stall_cycles_o(stall_cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    req_v_i = 0; req_x_cord_i = 0; req_y_cord_i = 0; req_epa_i = 0; req_data_i = 0;
    req_mask_i = 0; req_is_store_i = 0; req_invalid_i = 0; pkt_ready_i = 0;
    credit_return_i = 0; fence_v_i = 0; err_clear_i = 0;
  endtask

  // Returns credits while any are outstanding and lets the FIFO drain.
  task automatic drain();
    pkt_ready_i = 1;
    for (int c = 0; c < 80; c++) begin
      credit_return_i = (out_credits_o < 6'd32);
      tick();
    end
    credit_return_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1;
    tick(); tick();
    n_tests++; if (pkt_v_o !== 1'b0)          begin $display("FAIL reset_pkt_v got %0b exp 0", pkt_v_o); n_fail++; end
    n_tests++; if (out_credits_o !== 6'd32)   begin $display("FAIL reset_credits got %0d exp 32", out_credits_o); n_fail++; end
    n_tests++; if (fence_done_o !== 1'b0)     begin $display("FAIL reset_fence_done got %0b exp 0", fence_done_o); n_fail++; end
    n_tests++; if (err_o !== 1'b0)            begin $display("FAIL reset_err got %0b exp 0", err_o); n_fail++; end
    reset_i = 0;
    tick();
    n_tests++; if (req_ready_o !== 1'b1)      begin $display("FAIL reset_req_ready got %0b exp 1", req_ready_o); n_fail++; end
    n_tests++; if (fence_ready_o !== 1'b1)    begin $display("FAIL reset_fence_ready got %0b exp 1", fence_ready_o); n_fail++; end
  endtask

  task automatic test_basic_store();
    pkt_ready_i = 1;
    req_v_i = 1; req_x_cord_i = 7'd3; req_y_cord_i = 7'd2; req_epa_i = 28'h10;
    req_data_i = 32'hDEADBEEF; req_mask_i = 4'hF; req_is_store_i = 1;
    tick();
    req_v_i = 0;
    n_tests++; if (pkt_v_o !== 1'b1)          begin $display("FAIL basic_pkt_v got %0b exp 1", pkt_v_o); n_fail++; end
    n_tests++; if ({pkt_x_cord_o, pkt_y_cord_o, pkt_epa_o} !== {7'd3, 7'd2, 28'h10})
      begin $display("FAIL basic_addr got %0d,%0d,%h exp 3,2,10", pkt_x_cord_o, pkt_y_cord_o, pkt_epa_o); n_fail++; end
    n_tests++; if ({pkt_data_o, pkt_mask_o, pkt_is_store_o} !== {32'hDEADBEEF, 4'hF, 1'b1})
      begin $display("FAIL basic_data got %h/%h/%0b exp deadbeef/f/1", pkt_data_o, pkt_mask_o, pkt_is_store_o); n_fail++; end
    n_tests++; if (out_credits_o !== 6'd32)   begin $display("FAIL basic_credits_pre got %0d exp 32", out_credits_o); n_fail++; end
    tick();
    n_tests++; if (out_credits_o !== 6'd31)   begin $display("FAIL basic_credits_issue got %0d exp 31", out_credits_o); n_fail++; end
    n_tests++; if (pkt_v_o !== 1'b0)          begin $display("FAIL basic_pkt_v_after got %0b exp 0", pkt_v_o); n_fail++; end
    credit_return_i = 1;
    tick();
    credit_return_i = 0;
    n_tests++; if (out_credits_o !== 6'd32)   begin $display("FAIL basic_credit_return got %0d exp 32", out_credits_o); n_fail++; end
  endtask

  task automatic test_credit_limit();
    int sent = 0, issued = 0;
    logic acc, iss;
    pkt_ready_i = 1; req_is_store_i = 0;
    for (int c = 0; c < 200 && sent < 34; c++) begin
      req_v_i = 1; req_epa_i = 28'(sent);
      acc = req_ready_o; iss = pkt_v_o & pkt_ready_i;
      tick();
      if (acc) sent++;
      if (iss) issued++;
    end
    req_v_i = 0;
    n_tests++; if (sent !== 34)               begin $display("FAIL limit_sent got %0d exp 34", sent); n_fail++; end
    for (int c = 0; c < 5; c++) begin
      iss = pkt_v_o & pkt_ready_i;
      tick();
      if (iss) issued++;
    end
    n_tests++; if (issued !== 32)             begin $display("FAIL limit_issued got %0d exp 32", issued); n_fail++; end
    n_tests++; if (out_credits_o !== 6'd0)    begin $display("FAIL limit_credits got %0d exp 0", out_credits_o); n_fail++; end
    n_tests++; if (pkt_v_o !== 1'b0)          begin $display("FAIL limit_pkt_v got %0b exp 0", pkt_v_o); n_fail++; end
    n_tests++; if (req_ready_o !== 1'b0)      begin $display("FAIL limit_full_ready got %0b exp 0", req_ready_o); n_fail++; end
    n_tests++; if (pkt_epa_o !== 28'd32)      begin $display("FAIL limit_head_epa got %0d exp 32", pkt_epa_o); n_fail++; end
    credit_return_i = 1;
    tick();
    credit_return_i = 0;
    n_tests++; if (pkt_v_o !== 1'b1)          begin $display("FAIL limit_pkt_v_credit got %0b exp 1", pkt_v_o); n_fail++; end
    tick();
    n_tests++; if (out_credits_o !== 6'd0)    begin $display("FAIL limit_credits_33 got %0d exp 0", out_credits_o); n_fail++; end
    n_tests++; if (pkt_epa_o !== 28'd33)      begin $display("FAIL limit_head_epa_34 got %0d exp 33", pkt_epa_o); n_fail++; end
    drain();
    n_tests++; if (out_credits_o !== 6'd32)   begin $display("FAIL limit_drained_credits got %0d exp 32", out_credits_o); n_fail++; end
    n_tests++; if (pkt_v_o !== 1'b0)          begin $display("FAIL limit_drained_pkt_v got %0b exp 0", pkt_v_o); n_fail++; end
  endtask

  task automatic test_invalid();
    pkt_ready_i = 1;
    req_v_i = 1; req_invalid_i = 1; req_epa_i = 28'h123;
    tick();
    req_v_i = 0; req_invalid_i = 0;
    n_tests++; if (err_o !== 1'b1)            begin $display("FAIL invalid_err got %0b exp 1", err_o); n_fail++; end
    n_tests++; if (pkt_v_o !== 1'b0)          begin $display("FAIL invalid_pkt_v got %0b exp 0", pkt_v_o); n_fail++; end
    n_tests++; if (out_credits_o !== 6'd32)   begin $display("FAIL invalid_credits got %0d exp 32", out_credits_o); n_fail++; end
    err_clear_i = 1;
    tick();
    err_clear_i = 0;
    n_tests++; if (err_o !== 1'b0)            begin $display("FAIL invalid_clear got %0b exp 0", err_o); n_fail++; end
    req_v_i = 1; req_invalid_i = 1; err_clear_i = 1;
    tick();
    req_v_i = 0; req_invalid_i = 0; err_clear_i = 0;
    n_tests++; if (err_o !== 1'b1)            begin $display("FAIL invalid_set_wins got %0b exp 1", err_o); n_fail++; end
    err_clear_i = 1;
    tick();
    err_clear_i = 0;
    n_tests++; if (err_o !== 1'b0)            begin $display("FAIL invalid_clear2 got %0b exp 0", err_o); n_fail++; end
  endtask

  task automatic test_fence_wait();
    int pulses = 0;
    pkt_ready_i = 1; req_is_store_i = 1;
    for (int i = 0; i < 4; i++) begin
      req_v_i = 1; req_epa_i = 28'(i);
      tick();
    end
    req_v_i = 0;
    tick(); tick();
    n_tests++; if (out_credits_o !== 6'd28)   begin $display("FAIL fence_credits got %0d exp 28", out_credits_o); n_fail++; end
    fence_v_i = 1;
    tick();
    fence_v_i = 0;
    n_tests++; if (req_ready_o !== 1'b0)      begin $display("FAIL fence_req_ready got %0b exp 0", req_ready_o); n_fail++; end
    n_tests++; if (fence_ready_o !== 1'b0)    begin $display("FAIL fence_fence_ready got %0b exp 0", fence_ready_o); n_fail++; end
    for (int i = 0; i < 4; i++) begin
      credit_return_i = 1;
      tick();
      if (fence_done_o) pulses++;
    end
    credit_return_i = 0;
    n_tests++; if (req_ready_o !== 1'b0)      begin $display("FAIL fence_still_wait got %0b exp 0", req_ready_o); n_fail++; end
    tick();
    if (fence_done_o) pulses++;
    n_tests++; if (fence_done_o !== 1'b1)     begin $display("FAIL fence_done got %0b exp 1", fence_done_o); n_fail++; end
    n_tests++; if (req_ready_o !== 1'b1)      begin $display("FAIL fence_resume got %0b exp 1", req_ready_o); n_fail++; end
    tick();
    if (fence_done_o) pulses++;
    n_tests++; if (pulses !== 1)              begin $display("FAIL fence_pulses got %0d exp 1", pulses); n_fail++; end
  endtask

  task automatic test_fence_idle();
    fence_v_i = 1;
    tick();
    fence_v_i = 0;
    n_tests++; if (fence_done_o !== 1'b1)     begin $display("FAIL fence_idle_done got %0b exp 1", fence_done_o); n_fail++; end
    n_tests++; if (req_ready_o !== 1'b1)      begin $display("FAIL fence_idle_ready got %0b exp 1", req_ready_o); n_fail++; end
    tick();
    n_tests++; if (fence_done_o !== 1'b0)     begin $display("FAIL fence_idle_pulse got %0b exp 0", fence_done_o); n_fail++; end
  endtask

  task automatic test_fence_with_req();
    pkt_ready_i = 0;
    req_v_i = 1; fence_v_i = 1; req_epa_i = 28'h77;
    tick();
    req_v_i = 0; fence_v_i = 0;
    n_tests++; if (req_ready_o !== 1'b0)      begin $display("FAIL fence_req_blocked got %0b exp 0", req_ready_o); n_fail++; end
    n_tests++; if (pkt_v_o !== 1'b1 || pkt_epa_o !== 28'h77)
      begin $display("FAIL fence_req_queued got %0b/%h exp 1/77", pkt_v_o, pkt_epa_o); n_fail++; end
    pkt_ready_i = 1;
    tick();
    credit_return_i = 1;
    tick();
    credit_return_i = 0;
    n_tests++; if (fence_done_o !== 1'b0)     begin $display("FAIL fence_req_early got %0b exp 0", fence_done_o); n_fail++; end
    tick();
    n_tests++; if (fence_done_o !== 1'b1)     begin $display("FAIL fence_req_done got %0b exp 1", fence_done_o); n_fail++; end
  endtask

  task automatic test_stall_reset();
    reset_i = 1; tick(); reset_i = 0; tick();
    pkt_ready_i = 0;
    req_v_i = 1; req_x_cord_i = 7'd5; req_y_cord_i = 7'd1; req_epa_i = 28'h55;
    req_data_i = 32'hCAFEF00D; req_is_store_i = 1;
    tick();
    req_v_i = 0; req_data_i = 32'h0; req_epa_i = 28'h0;
    for (int c = 0; c < 10; c++) tick();
    n_tests++; if (pkt_v_o !== 1'b1 || pkt_epa_o !== 28'h55 || pkt_data_o !== 32'hCAFEF00D)
      begin $display("FAIL stall_fields got %0b/%h/%h exp 1/55/cafef00d", pkt_v_o, pkt_epa_o, pkt_data_o); n_fail++; end
`ifdef BSG_MANYCORE_NPA_REQ_STALL_CTR_EN
    n_tests++; if (stall_cycles_o !== 32'd10) begin $display("FAIL stall_count got %0d exp 10", stall_cycles_o); n_fail++; end
`endif
    #3 reset_i = 1;
    #1;
    n_tests++; if (pkt_v_o !== 1'b0)          begin $display("FAIL async_reset_pkt_v got %0b exp 0", pkt_v_o); n_fail++; end
    n_tests++; if (out_credits_o !== 6'd32)   begin $display("FAIL async_reset_credits got %0d exp 32", out_credits_o); n_fail++; end
`ifdef BSG_MANYCORE_NPA_REQ_STALL_CTR_EN
    n_tests++; if (stall_cycles_o !== 32'd0)  begin $display("FAIL async_reset_stall got %0d exp 0", stall_cycles_o); n_fail++; end
`endif
    tick();
    reset_i = 0;
    tick();
    n_tests++; if (pkt_v_o !== 1'b0 || req_ready_o !== 1'b1)
      begin $display("FAIL post_reset_empty got %0b/%0b exp 0/1", pkt_v_o, req_ready_o); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_basic_store();
    test_credit_limit();
    test_invalid();
    test_fence_wait();
    test_fence_idle();
    test_fence_with_req();
    test_stall_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
